// File: rtl/ym3438_bus_if_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ym3438_bus_if_if : host-side CPU bus bundle (strobes, address, data, OE)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ym3438_bus_if_if;
    logic       CS_n;
    logic       WR_n;
    logic       RD_n;
    logic [1:0] A;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       D_oe;

    modport master (output CS_n, WR_n, RD_n, A, D_in, input D_out, D_oe);
    modport slave  (input CS_n, WR_n, RD_n, A, D_in, output D_out, D_oe);
endinterface
`default_nettype wire

// File: rtl/ym3438_bus_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ym3438_bus_if : OPN2 CPU bus front end - synchronises host writes, replays  |
// | them as one-c1-cycle strobes, generates busy and the status read byte.      |
// | Optional: YM3438_STATUS_ALL_ADDR_EN makes status readable at all addresses. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ym3438_bus_if #(
    parameter int BUSY_CYCLES = 32
) (
    input  logic           MCLK,
    input  logic           nIC,
    input  logic           c1,
    input  logic           timer_a_ovf,
    input  logic           timer_b_ovf,
    ym3438_bus_if_if.slave host,
    output logic [7:0]     data,
    output logic           bank,
    output logic           write_addr_en,
    output logic           write_data_en,
    output logic           busy
);
    localparam logic [5:0] BUSY_LOAD = 6'(BUSY_CYCLES);

    logic [1:0] cs_sync_q, wr_sync_q, rd_sync_q;
    logic       wr_prev_q;
    logic [1:0] a_sync1_q, a_sync2_q;
    logic [7:0] d_sync1_q, d_sync2_q;

    logic       pending_q;
    logic [1:0] hold_a_q;
    logic [7:0] hold_d_q;

    logic [7:0] data_q;
    logic       bank_q, addr_en_q, data_en_q;
    logic [5:0] busy_cnt_q, busy_cnt_d;

    logic [7:0] dout_q;
    logic       doe_q;

    logic       capture, issue, addr_ok, rd_active;

    // Strobe synchronisers reset to the inactive (high) level so that leaving
    // reset never looks like a host access or a WR_n rising edge.
    always_ff @(posedge MCLK or posedge nIC) begin
        if (nIC) begin
            cs_sync_q <= 2'b11;
            wr_sync_q <= 2'b11;
            rd_sync_q <= 2'b11;
            wr_prev_q <= 1'b1;
            a_sync1_q <= 2'b00;
            a_sync2_q <= 2'b00;
            d_sync1_q <= 8'h00;
            d_sync2_q <= 8'h00;
        end else begin
            cs_sync_q <= {cs_sync_q[0], host.CS_n};
            wr_sync_q <= {wr_sync_q[0], host.WR_n};
            rd_sync_q <= {rd_sync_q[0], host.RD_n};
            wr_prev_q <= wr_sync_q[1];
            a_sync1_q <= host.A;
            a_sync2_q <= a_sync1_q;
            d_sync1_q <= host.D_in;
            d_sync2_q <= d_sync1_q;
        end
    end

    assign capture = wr_sync_q[1] & ~wr_prev_q & ~cs_sync_q[1];
    assign issue   = c1 & pending_q;

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (c1) begin
            if (issue && hold_a_q[0])
                busy_cnt_d = BUSY_LOAD;
            else if (busy_cnt_q != 6'd0)
                busy_cnt_d = busy_cnt_q - 6'd1;
        end
    end

    // Issue reads the old holding register before a same-edge capture replaces it.
    always_ff @(posedge MCLK or posedge nIC) begin
        if (nIC) begin
            pending_q  <= 1'b0;
            hold_a_q   <= 2'b00;
            hold_d_q   <= 8'h00;
            data_q     <= 8'h00;
            bank_q     <= 1'b0;
            addr_en_q  <= 1'b0;
            data_en_q  <= 1'b0;
            busy_cnt_q <= 6'd0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            if (c1) begin
                addr_en_q <= issue & ~hold_a_q[0];
                data_en_q <= issue &  hold_a_q[0];
                if (issue) begin
                    data_q    <= hold_d_q;
                    bank_q    <= hold_a_q[1];
                    pending_q <= 1'b0;
                end
            end
            if (capture) begin
                hold_a_q  <= a_sync2_q;
                hold_d_q  <= d_sync2_q;
                pending_q <= 1'b1;
            end
        end
    end

`ifdef YM3438_STATUS_ALL_ADDR_EN
    assign addr_ok = 1'b1;
`else
    assign addr_ok = (a_sync2_q == 2'b00);
`endif

    assign rd_active = ~cs_sync_q[1] & ~rd_sync_q[1] & addr_ok;

    always_ff @(posedge MCLK or posedge nIC) begin
        if (nIC) begin
            dout_q <= 8'h00;
            doe_q  <= 1'b0;
        end else begin
            dout_q <= {busy, 5'b00000, timer_b_ovf, timer_a_ovf};
            doe_q  <= rd_active;
        end
    end

    assign data          = data_q;
    assign bank          = bank_q;
    assign write_addr_en = addr_en_q;
    assign write_data_en = data_en_q;
    assign busy          = (busy_cnt_q != 6'd0);
    assign host.D_out    = dout_q;
    assign host.D_oe     = doe_q;
endmodule
`default_nettype wire

// File: tb/tb_ym3438_bus_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ym3438_bus_if : directed bench with a cycle-level model of the bus front |
// | end and literal expectations for the key scenarios.                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ym3438_bus_if;
    localparam int BUSY = 32;
    localparam int C1_DIV = 6;

    logic       MCLK = 1'b0;
    logic       nIC = 1'b1;
    logic       c1 = 1'b0;
    logic       c1_en = 1'b1;
    logic       timer_a_ovf = 1'b0;
    logic       timer_b_ovf = 1'b0;
    logic [7:0] data;
    logic       bank, write_addr_en, write_data_en, busy;
    int         div = 0;

    int n_checks = 0;
    int n_fail = 0;
    int n_addr = 0;
    int n_data = 0;

    ym3438_bus_if_if bus ();

    ym3438_bus_if #(.BUSY_CYCLES(BUSY)) dut (
        .MCLK(MCLK), .nIC(nIC), .c1(c1),
        .timer_a_ovf(timer_a_ovf), .timer_b_ovf(timer_b_ovf),
        .host(bus),
        .data(data), .bank(bank),
        .write_addr_en(write_addr_en), .write_data_en(write_data_en),
        .busy(busy)
    );

    always #5 MCLK = ~MCLK;

    always @(negedge MCLK) begin
        div = (div == C1_DIV - 1) ? 0 : div + 1;
        c1  = c1_en && (div == 0);
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit addr_valid(logic [1:0] a);
`ifdef YM3438_STATUS_ALL_ADDR_EN
        return 1'b1;
`else
        return a == 2'b00;
`endif
    endfunction

    // Model: inputs seen at the last four edges; a write completes when WR_n was
    // low three edges ago and high two edges ago with CS_n low.
    logic       h_cs[4], h_wr[4], h_rd[4];
    logic [1:0] h_a[4];
    logic [7:0] h_d[4];
    logic       m_pend = 0, m_bank = 0, m_aen = 0, m_den = 0, m_doe = 0;
    logic [1:0] m_ha = 0;
    logic [7:0] m_hd = 0, m_data = 0, m_dout = 0;
    int         m_cnt = 0;
    logic       prev_aen = 0, prev_den = 0;

    initial for (int i = 0; i < 4; i++) begin
        h_cs[i] = 1; h_wr[i] = 1; h_rd[i] = 1; h_a[i] = 0; h_d[i] = 0;
    end

    always begin
        bit old_busy;
        @(posedge MCLK);
        #1;
        if (nIC) begin
            for (int i = 0; i < 4; i++) begin
                h_cs[i] = 1; h_wr[i] = 1; h_rd[i] = 1; h_a[i] = 0; h_d[i] = 0;
            end
            m_pend = 0; m_ha = 0; m_hd = 0; m_data = 0; m_bank = 0;
            m_aen = 0; m_den = 0; m_cnt = 0; m_dout = 0; m_doe = 0;
        end else begin
            for (int i = 3; i > 0; i--) begin
                h_cs[i] = h_cs[i-1]; h_wr[i] = h_wr[i-1]; h_rd[i] = h_rd[i-1];
                h_a[i] = h_a[i-1]; h_d[i] = h_d[i-1];
            end
            h_cs[0] = bus.CS_n; h_wr[0] = bus.WR_n; h_rd[0] = bus.RD_n;
            h_a[0] = bus.A; h_d[0] = bus.D_in;
            old_busy = (m_cnt != 0);
            if (c1) begin
                if (m_pend) begin
                    m_data = m_hd; m_bank = m_ha[1];
                    m_aen = !m_ha[0]; m_den = m_ha[0]; m_pend = 0;
                end else begin
                    m_aen = 0; m_den = 0;
                end
                if (m_den) m_cnt = BUSY;
                else if (m_cnt > 0) m_cnt--;
            end
            if (h_wr[2] && !h_wr[3] && !h_cs[2]) begin
                m_ha = h_a[2]; m_hd = h_d[2]; m_pend = 1;
            end
            m_doe  = !h_cs[2] && !h_rd[2] && addr_valid(h_a[2]);
            m_dout = {old_busy, 5'b00000, timer_b_ovf, timer_a_ovf};
        end
        chk("data", data, m_data);
        chk("bank", bank, m_bank);
        chk("write_addr_en", write_addr_en, m_aen);
        chk("write_data_en", write_data_en, m_den);
        chk("busy", busy, m_cnt != 0);
        chk("D_out", bus.D_out, m_dout);
        chk("D_oe", bus.D_oe, m_doe);
        if (write_addr_en && !prev_aen) n_addr++;
        if (write_data_en && !prev_den) n_data++;
        prev_aen = write_addr_en;
        prev_den = write_data_en;
    end

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge MCLK);
        bus.CS_n = 0; bus.A = a; bus.D_in = d; bus.WR_n = 0;
        repeat (2) @(negedge MCLK);
        bus.WR_n = 1;
        repeat (4) @(negedge MCLK);
        bus.CS_n = 1;
    endtask

    task automatic wait_issue();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge MCLK); #1;
            if (write_addr_en || write_data_en) begin ok = 1; break; end
        end
        chk("issue_timeout", ok, 1);
    endtask

    task automatic count_busy(output int n);
        bit ok = 0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge MCLK); #1;
            if (c1) n++;
            if (!busy) begin ok = 1; break; end
        end
        chk("busy_timeout", ok, 1);
    endtask

    task automatic set_c1_en(input logic en);
        @(posedge MCLK); #2;
        c1_en = en;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, seen;
        bus.CS_n = 1; bus.WR_n = 1; bus.RD_n = 1; bus.A = 0; bus.D_in = 0;

        repeat (3) @(posedge MCLK);
        #1;
        chk("rst_data", data, 8'h00);
        chk("rst_bank", bank, 0);
        chk("rst_aen", write_addr_en, 0);
        chk("rst_den", write_data_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", bus.D_out, 8'h00);
        chk("rst_doe", bus.D_oe, 0);
        @(negedge MCLK); nIC = 0;
        repeat (4) @(negedge MCLK);

        // Address write 0x28
        timer_b_ovf = 1;
        host_write(2'b00, 8'h28);
        wait_issue();
        chk("aw_data", data, 8'h28);
        chk("aw_bank", bank, 0);
        chk("aw_aen", write_addr_en, 1);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge MCLK); #1;
            if (!write_addr_en) break;
            n++;
        end
        chk("aw_width", n, C1_DIV);
        chk("aw_busy", busy, 0);
        chk("aw_hold", data, 8'h28);
        timer_b_ovf = 0;

        // Data write 0xF1 at bank 1
        host_write(2'b11, 8'hF1);
        wait_issue();
        chk("dw_data", data, 8'hF1);
        chk("dw_bank", bank, 1);
        chk("dw_den", write_data_en, 1);
        chk("dw_busy", busy, 1);
        count_busy(n);
        chk("dw_busy_len", n, BUSY);

        // Two address writes before issue: last wins
        set_c1_en(0);
        host_write(2'b00, 8'h30);
        host_write(2'b00, 8'h40);
        repeat (4) @(negedge MCLK);
        base = n_addr;
        set_c1_en(1);
        wait_issue();
        chk("ow_data", data, 8'h40);
        repeat (3 * C1_DIV) @(posedge MCLK);
        #1;
        chk("ow_pulses", n_addr - base, 1);

        // Data write with counter at 5 reloads to full length
        host_write(2'b01, 8'h77);
        wait_issue();
        seen = 0;
        for (int i = 0; i < 1000 && seen < BUSY - 5; i++) begin
            @(posedge MCLK); #1;
            if (c1) seen++;
        end
        c1_en = 0;
        chk("rl_pre_busy", busy, 1);
        host_write(2'b11, 8'hA5);
        repeat (4) @(negedge MCLK);
        set_c1_en(1);
        wait_issue();
        chk("rl_data", data, 8'hA5);
        count_busy(n);
        chk("rl_busy_len", n, BUSY);

        // Status read while busy
        host_write(2'b01, 8'h12);
        wait_issue();
        @(negedge MCLK);
        bus.CS_n = 0; bus.RD_n = 0; bus.A = 2'b10; timer_a_ovf = 1;
        repeat (4) @(posedge MCLK);
        #1;
        chk("rd_dout", bus.D_out, 8'h81);
`ifdef YM3438_STATUS_ALL_ADDR_EN
        chk("rd_doe_a2", bus.D_oe, 1);
`else
        chk("rd_doe_a2", bus.D_oe, 0);
`endif
        @(negedge MCLK); bus.A = 2'b00;
        repeat (4) @(posedge MCLK);
        #1;
        chk("rd_doe_a0", bus.D_oe, 1);
        @(negedge MCLK); bus.CS_n = 1; bus.RD_n = 1; timer_a_ovf = 0;
        repeat (4) @(posedge MCLK);
        #1;
        chk("rd_doe_off", bus.D_oe, 0);

        // Reset while a write is pending and busy is high
        set_c1_en(0);
        host_write(2'b01, 8'h55);
        repeat (4) @(negedge MCLK);
        chk("ic_pre_busy", busy, 1);
        @(negedge MCLK); nIC = 1;
        #1;
        chk("ic_async_clear", {data, bank, write_addr_en, write_data_en, busy, bus.D_out, bus.D_oe}, 0);
        repeat (3) @(negedge MCLK);
        base = n_data + n_addr;
        nIC = 0;
        c1_en = 1;
        repeat (10 * C1_DIV) @(posedge MCLK);
        #1;
        chk("ic_no_strobe", n_data + n_addr - base, 0);
        chk("ic_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
